// File: rtl/mandel_color_sched.sv
// mandel_color_sched: round-robin scheduler sharing one registered palette LUT
// among NUM_ENG Mandelbrot engines, with a two-entry output pipeline and
// per-frame drain/swap of the max-iteration shadow.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   cfg_max_iter                requested max iterations (sampled in SWAP)
//   req_valid/req_depth/req_addr  per-engine results, packed per engine
//   req_ready                   one-hot (or zero) accept, combinational
//   lut_en/lut_depth            LUT issue strobe and depth, combinational
//   lut_max_iter                registered max-iteration shadow for the LUT
//   lut_color                   LUT registered output
//   pix_valid/pix_ready/pix_addr/pix_color  output pixel stream
//   frame_done                  one-cycle pulse at each frame boundary
module mandel_color_sched #(
    parameter int unsigned NUM_ENG      = 4,
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned FRAME_PIXELS = 307200
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [9:0]                cfg_max_iter,
    input  logic [NUM_ENG-1:0]        req_valid,
    input  logic [NUM_ENG*10-1:0]     req_depth,
    input  logic [NUM_ENG*ADDR_W-1:0] req_addr,
    output logic [NUM_ENG-1:0]        req_ready,
    output logic                      lut_en,
    output logic [9:0]                lut_depth,
    output logic [9:0]                lut_max_iter,
    input  logic [23:0]               lut_color,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [ADDR_W-1:0]         pix_addr,
    output logic [23:0]               pix_color,
    output logic                      frame_done
);

    localparam int unsigned DEPTH_W = 10;
    localparam int unsigned PTR_W   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int unsigned CNT_W   = $clog2(FRAME_PIXELS + 1);

    typedef enum logic [1:0] {SWAP, RUN, DRAIN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PTR_W-1:0]    ptr;
    logic [CNT_W-1:0]    issue_cnt;
    logic                s1_valid;
    logic [ADDR_W-1:0]   s1_addr;
    logic                out_load;
    logic                issue_ok;
    logic                issue;
    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic [31:0]         grant_sel;
    logic                last_issue;
    logic                drained;

    // Engine index base+off wrapped into 0..NUM_ENG-1.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_ENG) sum = sum - NUM_ENG;
        return PTR_W'(sum);
    endfunction

    assign out_load   = s1_valid & (~pix_valid | pix_ready);
    assign issue_ok   = (state == RUN) & (~s1_valid | out_load);
    assign issue      = issue_ok & grant_found;
    assign grant_sel  = 32'(grant_idx);
    assign last_issue = issue & (issue_cnt == CNT_W'(FRAME_PIXELS - 1));
    assign drained    = ~s1_valid & ~pix_valid;
    assign lut_en     = issue;

    // Round-robin search starting at ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_ENG; k++) begin
            if (!grant_found && req_valid[wrap_idx(ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(ptr, k);
            end
        end
    end

    // Accept strobe and LUT depth only on issue cycles; depth is 0 otherwise.
    always_comb begin
        req_ready = '0;
        lut_depth = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
            lut_depth            = req_depth[grant_sel*DEPTH_W +: DEPTH_W];
        end
    end

    // Frame sequencing.
    always_comb begin
        state_nxt = state;
        unique case (state)
            SWAP:    state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = SWAP;
            default: state_nxt = SWAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SWAP;
            ptr          <= '0;
            issue_cnt    <= '0;
            s1_valid     <= 1'b0;
            s1_addr      <= '0;
            pix_valid    <= 1'b0;
            pix_addr     <= '0;
            pix_color    <= '0;
            lut_max_iter <= '0;
            frame_done   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Leaving DRAIN means the next cycle is a SWAP that ends a frame;
            // the SWAP straight out of reset never gets here.
            frame_done <= (state == DRAIN) & drained;

            if (state == SWAP) begin
                lut_max_iter <= cfg_max_iter;
                issue_cnt    <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end

            if (issue) begin
                ptr      <= (grant_idx == PTR_W'(NUM_ENG - 1)) ? '0 : grant_idx + PTR_W'(1);
                s1_addr  <= req_addr[grant_sel*ADDR_W +: ADDR_W];
                s1_valid <= 1'b1;
            end else if (out_load) begin
                s1_valid <= 1'b0;
            end

            // LUT output holds while lut_en is low, so a stalled s1 entry
            // still finds its colour on lut_color when it finally loads.
            if (out_load) begin
                pix_valid <= 1'b1;
                pix_addr  <= s1_addr;
                pix_color <= lut_color;
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mandel_color_sched.sv
module tb_mandel_color_sched;

    localparam int unsigned NE = 4;
    localparam int unsigned AW = 19;
    localparam int unsigned FP = 8;

    typedef struct {
        logic [9:0]    depth;
        logic [AW-1:0] addr;
    } req_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   color;
        int            icyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [9:0]       cfg_max_iter = 10'd255;
    logic [NE-1:0]    req_valid = '0;
    logic [NE*10-1:0] req_depth = '0;
    logic [NE*AW-1:0] req_addr = '0;
    logic [NE-1:0]    req_ready;
    logic             lut_en;
    logic [9:0]       lut_depth;
    logic [9:0]       lut_max_iter;
    logic [23:0]      lut_color = '0;
    logic             pix_valid;
    logic             pix_ready = 1'b1;
    logic [AW-1:0]    pix_addr;
    logic [23:0]      pix_color;
    logic             frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int out_cnt = 0;
    int fd_cnt = 0;
    int mi_chg_cyc = -1;

    req_t eng_q [NE][$];
    exp_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   out_cyc[$];
    int   fd_cyc[$];

    logic [NE-1:0] en_mask = '1;
    bit            rand_mask = 1'b0;
    bit            rand_ready = 1'b0;
    bit            lat_chk = 1'b0;
    logic [9:0]    prev_mi = '0;

    int exp_rr_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_rr_b[6] = '{0, 1, 3, 0, 1, 3};

    mandel_color_sched #(
        .NUM_ENG(NE),
        .ADDR_W(AW),
        .FRAME_PIXELS(FP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_max_iter(cfg_max_iter),
        .req_valid(req_valid),
        .req_depth(req_depth),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .lut_en(lut_en),
        .lut_depth(lut_depth),
        .lut_max_iter(lut_max_iter),
        .lut_color(lut_color),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_addr(pix_addr),
        .pix_color(pix_color),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Palette model: any injective depth->colour map, registered with enable.
    function automatic logic [23:0] color_of(input logic [9:0] d);
        return {d, ~d, 4'h5};
    endfunction

    always @(posedge clk) begin
        if (lut_en) lut_color <= color_of(lut_depth);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string t);
        chk({t, "_req_ready"},    64'(req_ready),    64'd0);
        chk({t, "_lut_en"},       64'(lut_en),       64'd0);
        chk({t, "_lut_depth"},    64'(lut_depth),    64'd0);
        chk({t, "_lut_max_iter"}, 64'(lut_max_iter), 64'd0);
        chk({t, "_pix_valid"},    64'(pix_valid),    64'd0);
        chk({t, "_pix_addr"},     64'(pix_addr),     64'd0);
        chk({t, "_pix_color"},    64'(pix_color),    64'd0);
        chk({t, "_frame_done"},   64'(frame_done),   64'd0);
    endtask

    task automatic fill(input int e, input int n, input int base);
        for (int k = 0; k < n; k++)
            eng_q[e].push_back('{depth: 10'($urandom_range(0, 1023)), addr: AW'(base + k)});
    endtask

    // One clock cycle: drive inputs, sample mid-cycle, score handshakes.
    task automatic tick();
        exp_t e;
        for (int i = 0; i < int'(NE); i++) begin
            if (rand_mask) en_mask[i] = ($urandom_range(0, 3) != 0);
            req_valid[i] = en_mask[i] && (eng_q[i].size() > 0);
            if (eng_q[i].size() > 0) begin
                req_depth[i*10 +: 10] = eng_q[i][0].depth;
                req_addr[i*AW +: AW]  = eng_q[i][0].addr;
            end else begin
                req_depth[i*10 +: 10] = '0;
                req_addr[i*AW +: AW]  = '0;
            end
        end
        if (rand_ready) pix_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (rst_n) begin
            chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            chk("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
            chk("lut_en_vs_accept", 64'(lut_en), 64'(|req_ready));
            if (!lut_en) chk("lut_depth_idle", 64'(lut_depth), 64'd0);
            if (lut_max_iter !== prev_mi) begin
                chk("max_iter_change_busy", 64'(sb.size()), 64'd0);
                mi_chg_cyc = cyc;
            end
        end
        prev_mi = lut_max_iter;
        for (int i = 0; i < int'(NE); i++) begin
            if (req_valid[i] && req_ready[i]) begin
                chk("lut_depth", 64'(lut_depth), 64'(eng_q[i][0].depth));
                sb.push_back('{addr: eng_q[i][0].addr, color: color_of(eng_q[i][0].depth), icyc: cyc});
                grant_log.push_back(i);
                grant_cyc.push_back(cyc);
                void'(eng_q[i].pop_front());
            end
        end
        if (pix_valid && pix_ready) begin
            chk("pixel_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pix_addr", 64'(pix_addr), 64'(e.addr));
                chk("pix_color", 64'(pix_color), 64'(e.color));
                if (lat_chk) chk("latency", 64'(cyc - e.icyc), 64'd2);
                out_cnt++;
                out_cyc.push_back(cyc);
            end
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < int'(NE); i++) eng_q[i].delete();
        tick();
        tick();
        grant_log.delete();
        grant_cyc.delete();
        out_cyc.delete();
        fd_cyc.delete();
        out_cnt = 0;
        fd_cnt = 0;
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    initial begin
        int held_addr;
        int n_before;

        // Power-on reset values.
        #1 rst_n = 1'b0;
        #1 chk_reset_outs("por");

        // Single engine, three depths, latency and first grant after reset.
        pix_ready = 1'b1;
        lat_chk = 1'b1;
        do_reset();
        eng_q[0].push_back('{depth: 10'd0,    addr: AW'(0)});
        eng_q[0].push_back('{depth: 10'd5,    addr: AW'(1)});
        eng_q[0].push_back('{depth: 10'd1023, addr: AW'(2)});
        repeat (8) tick();
        chk("t1_grants", 64'(grant_cyc.size()), 64'd3);
        if (grant_cyc.size() == 3) chk("t1_first_grant_cycle", 64'(grant_cyc[0] - rel_cyc), 64'd1);
        chk("t1_out_count", 64'(out_cnt), 64'd3);
        if (out_cyc.size() == 3) chk("t1_back_to_back", 64'(out_cyc[2] - out_cyc[0]), 64'd2);
        chk("t1_max_iter", 64'(lut_max_iter), 64'd255);

        // Round-robin over all engines, then with engine 2 idle.
        do_reset();
        for (int i = 0; i < int'(NE); i++) fill(i, 12, i * 256);
        for (int n = 0; n < 40 && grant_log.size() < 8; n++) tick();
        chk("t2_grants_a", 64'(grant_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            chk("t2_rr_order_a", 64'(grant_log[k]), 64'(exp_rr_a[k]));
        if (grant_cyc.size() >= 8) chk("t2_throughput", 64'(grant_cyc[7] - grant_cyc[0]), 64'd7);
        en_mask = 4'b1011;
        for (int n = 0; n < 40 && grant_log.size() < 14; n++) tick();
        chk("t2_grants_b", 64'(grant_log.size()), 64'd14);
        for (int k = 0; k < 6 && k + 8 < grant_log.size(); k++)
            chk("t2_rr_order_b", 64'(grant_log[k + 8]), 64'(exp_rr_b[k]));
        if (grant_cyc.size() >= 9) chk("t2_frame_gap", 64'((grant_cyc[8] - grant_cyc[7]) >= 3), 64'd1);
        chk("t2_frame_done", 64'(fd_cnt), 64'd1);
        en_mask = '0;
        repeat (6) tick();
        chk("t2_drained", 64'(sb.size()), 64'd0);
        en_mask = '1;

        // Backpressure for 10 cycles mid-stream.
        lat_chk = 1'b0;
        do_reset();
        for (int i = 0; i < int'(NE); i++) fill(i, 3, 1000 + i * 16);
        repeat (4) tick();
        pix_ready = 1'b0;
        held_addr = int'(pix_addr);
        n_before = grant_log.size();
        repeat (10) tick();
        chk("t3_in_flight", 64'(sb.size()), 64'd2);
        chk("t3_no_grants", 64'(grant_log.size() - n_before), 64'd0);
        chk("t3_req_ready_low", 64'(req_ready), 64'd0);
        chk("t3_lut_en_low", 64'(lut_en), 64'd0);
        chk("t3_pix_valid_held", 64'(pix_valid), 64'd1);
        chk("t3_pix_addr_held", 64'(pix_addr), 64'(held_addr));
        pix_ready = 1'b1;
        for (int n = 0; n < 80 && out_cnt < 12; n++) tick();
        chk("t3_out_count", 64'(out_cnt), 64'd12);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Max-iteration change only lands at the frame boundary.
        cfg_max_iter = 10'd255;
        do_reset();
        fill(0, 10, 2000);
        for (int n = 0; n < 20 && grant_log.size() < 3; n++) tick();
        cfg_max_iter = 10'd100;
        for (int n = 0; n < 40 && fd_cnt < 1; n++) tick();
        repeat (2) tick();
        chk("t4_frame_done_once", 64'(fd_cnt), 64'd1);
        if (out_cyc.size() >= 8 && fd_cyc.size() >= 1) begin
            chk("t4_done_after_8th", 64'(out_cyc[7] < fd_cyc[0]), 64'd1);
            chk("t4_max_iter_after_swap", 64'(mi_chg_cyc), 64'(fd_cyc[0] + 1));
        end
        chk("t4_max_iter_new", 64'(lut_max_iter), 64'd100);

        // Reset with s1 and output both full.
        do_reset();
        pix_ready = 1'b0;
        fill(1, 4, 3000);
        for (int n = 0; n < 20 && sb.size() != 2; n++) tick();
        chk("t5_filled", 64'(sb.size()), 64'd2);
        rst_n = 1'b0;
        #1 chk_reset_outs("t5");
        do_reset();
        pix_ready = 1'b1;
        fill(2, 2, 4000);
        repeat (5) tick();
        chk("t5_grants", 64'(grant_cyc.size()), 64'd2);
        if (grant_cyc.size() >= 1) chk("t5_first_grant_cycle", 64'(grant_cyc[0] - rel_cyc), 64'd1);
        chk("t5_no_frame_done", 64'(fd_cnt), 64'd0);
        chk("t5_out_count", 64'(out_cnt), 64'd2);

        // Random valid/ready stress over 24 frames.
        do_reset();
        for (int i = 0; i < int'(NE); i++) fill(i, 48, i * 4096);
        rand_mask = 1'b1;
        rand_ready = 1'b1;
        for (int n = 0; n < 3000 && fd_cnt < 24; n++) tick();
        rand_mask = 1'b0;
        rand_ready = 1'b0;
        pix_ready = 1'b1;
        chk("t6_frames", 64'(fd_cnt), 64'd24);
        chk("t6_out_count", 64'(out_cnt), 64'd192);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
